// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port read memory among NUM_REQ requesters.
// Each grant runs one IDLE -> ISSUE -> CAPTURE access and returns the data tagged with the winner id.
module mem_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int WAIT_CYC = 1,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    output logic [NUM_REQ-1:0]        o_gnt,
    output logic                      o_rvalid,
    output logic [DATA_W-1:0]         o_rdata,
    output logic [ID_W-1:0]           o_rid,
    output logic                      o_busy,
    output logic                      o_mem_read,
    output logic                      o_mem_enable,
    output logic [ADDR_W-1:0]         o_mem_addr,
    input  logic [DATA_W-1:0]         i_mem_data
);

    localparam int CNT_W = $clog2(WAIT_CYC) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [ID_W-1:0]      r_ptr;
    logic [ID_W-1:0]      r_winner;
    logic [CNT_W-1:0]     r_wait;
    logic [NUM_REQ-1:0]   r_gnt;
    logic                 r_rvalid;
    logic [DATA_W-1:0]    r_rdata;
    logic [ID_W-1:0]      r_rid;
    logic                 r_busy;
    logic                 r_mem_read;
    logic                 r_mem_enable;
    logic [ADDR_W-1:0]    r_mem_addr;

    logic                 w_found;
    logic [ID_W-1:0]      w_winner;
    logic [NUM_REQ-1:0]   w_gnt_onehot;
    logic [ADDR_W-1:0]    w_addr_sel;
    logic                 w_wait_done;

    // Scan starts at the pointer so the most recent winner has lowest priority next time.
    always_comb begin
        int idx;
        idx          = 0;
        w_found      = 1'b0;
        w_winner     = '0;
        w_gnt_onehot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_found && i_req[idx]) begin
                w_found  = 1'b1;
                w_winner = ID_W'(idx);
            end
        end
        w_gnt_onehot[w_winner] = w_found;
        w_addr_sel = i_req_addr[int'(w_winner)*ADDR_W +: ADDR_W];
    end

    assign w_wait_done = (r_wait == CNT_W'(WAIT_CYC - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_found) w_state_next = S_ISSUE;
            S_ISSUE:   if (w_wait_done) w_state_next = S_CAPTURE;
            S_CAPTURE: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_winner     <= '0;
            r_wait       <= '0;
            r_gnt        <= '0;
            r_rvalid     <= 1'b0;
            r_rdata      <= '0;
            r_rid        <= '0;
            r_busy       <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_enable <= 1'b0;
            r_mem_addr   <= '0;
        end else begin
            r_gnt    <= '0;
            r_rvalid <= 1'b0;
            r_busy   <= (w_state_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt        <= w_gnt_onehot;
                        r_winner     <= w_winner;
                        r_mem_addr   <= w_addr_sel;
                        r_mem_read   <= 1'b1;
                        r_mem_enable <= 1'b1;
                        r_wait       <= '0;
                    end
                end
                S_ISSUE: begin
                    if (!w_wait_done) begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    // mem_addr deliberately keeps its last value here.
                    r_rdata      <= i_mem_data;
                    r_rid        <= r_winner;
                    r_rvalid     <= 1'b1;
                    r_mem_read   <= 1'b0;
                    r_mem_enable <= 1'b0;
                    r_ptr        <= (r_winner == ID_W'(NUM_REQ - 1)) ? '0 : r_winner + 1'b1;
                end
                default: begin
                    r_mem_read   <= 1'b0;
                    r_mem_enable <= 1'b0;
                end
            endcase
        end
    end

    assign o_gnt        = r_gnt;
    assign o_rvalid     = r_rvalid;
    assign o_rdata      = r_rdata;
    assign o_rid        = r_rid;
    assign o_busy       = r_busy;
    assign o_mem_read   = r_mem_read;
    assign o_mem_enable = r_mem_enable;
    assign o_mem_addr   = r_mem_addr;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter: directed vector table, reset and pulse corner cases,
// then random request masks checked against a transaction-level round-robin model.
module tb_mem_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  i_req;
    logic [31:0] i_req_addr;
    logic [3:0]  o_gnt;
    logic        o_rvalid;
    logic [7:0]  o_rdata;
    logic [1:0]  o_rid;
    logic        o_busy;
    logic        o_mem_read;
    logic        o_mem_enable;
    logic [7:0]  o_mem_addr;
    logic [7:0]  memData;
    logic [7:0]  mem [256];

    int nVectors;
    int nFail;
    int refPtr;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] addrs;
        int          expWin;
        logic [7:0]  expData;
    } vec_t;

    vec_t vecs [10];

    mem_rr_arbiter #(
        .NUM_REQ (4),
        .ADDR_W  (8),
        .DATA_W  (8),
        .WAIT_CYC(1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (i_req),
        .i_req_addr  (i_req_addr),
        .o_gnt       (o_gnt),
        .o_rvalid    (o_rvalid),
        .o_rdata     (o_rdata),
        .o_rid       (o_rid),
        .o_busy      (o_busy),
        .o_mem_read  (o_mem_read),
        .o_mem_enable(o_mem_enable),
        .o_mem_addr  (o_mem_addr),
        .i_mem_data  (memData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory: data follows the enabled address one edge later.
    always @(posedge clk) begin
        if (o_mem_enable && o_mem_read) memData <= mem[o_mem_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Round-robin reference: the winner is the requesting index closest at or after the pointer.
    function automatic int modelWinner(input logic [3:0] mask, input int ptr);
        int best;
        int bestDist;
        best     = -1;
        bestDist = 99;
        for (int i = 0; i < 4; i++) begin
            if (mask[i] && ((i - ptr + 4) % 4) < bestDist) begin
                bestDist = (i - ptr + 4) % 4;
                best     = i;
            end
        end
        return best;
    endfunction

    // Drives one request set from an idle arbiter and checks the complete grant/read transaction.
    task automatic applyStimulus(input logic [3:0] mask, input logic [31:0] addrs,
                                 input int expWin, input logic [7:0] expData);
        int  waitCyc;
        bit  got;
        i_req      = mask;
        i_req_addr = addrs;
        got        = 1'b0;
        waitCyc    = 0;
        while (waitCyc < 12 && !got) begin
            @(negedge clk);
            waitCyc++;
            if (o_gnt != 4'b0) got = 1'b1;
        end
        if (!got) begin
            checkOutput("gnt_timeout", 32'd0, 32'd1);
            i_req = 4'b0;
            return;
        end
        checkOutput("gnt_latency", waitCyc, 1);
        checkOutput("gnt", o_gnt, 32'd1 << expWin);
        checkOutput("mem_strobe", {o_mem_read, o_mem_enable}, 2'b11);
        checkOutput("mem_addr", o_mem_addr, addrs[expWin*8 +: 8]);
        checkOutput("busy_high", o_busy, 1);
        i_req = mask & ~o_gnt;
        @(negedge clk);
        checkOutput("gnt_pulse", o_gnt, 0);
        checkOutput("rvalid_early", o_rvalid, 0);
        @(negedge clk);
        checkOutput("rvalid", o_rvalid, 1);
        checkOutput("rdata", o_rdata, expData);
        checkOutput("rid", o_rid, expWin);
        checkOutput("mem_en_gap", o_mem_enable, 0);
        checkOutput("busy_low", o_busy, 0);
        i_req  = 4'b0;
        refPtr = (expWin + 1) % 4;
    endtask

    initial begin
        int gnt1Count;
        int rid1Count;
        int rvalidCount;
        int expWin;
        logic [3:0]  mask;
        logic [31:0] addrs;
        bit got;

        nVectors   = 0;
        nFail      = 0;
        refPtr     = 0;
        i_req      = 4'b0;
        i_req_addr = 32'b0;
        rst_n      = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i >> 1);

        vecs[0] = '{4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, 0, 8'd5};
        vecs[1] = '{4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, 1, 8'd10};
        vecs[2] = '{4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, 2, 8'd15};
        vecs[3] = '{4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, 3, 8'd20};
        vecs[4] = '{4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, 0, 8'd5};
        vecs[5] = '{4'b0100, {8'd0, 8'd70, 8'd0, 8'd0}, 2, 8'd35};
        vecs[6] = '{4'b1001, {8'd200, 8'd0, 8'd0, 8'd9}, 3, 8'd100};
        vecs[7] = '{4'b0001, {8'd200, 8'd0, 8'd0, 8'd9}, 0, 8'd4};
        vecs[8] = '{4'b0010, {8'd0, 8'd0, 8'd150, 8'd0}, 1, 8'd75};
        vecs[9] = '{4'b0010, {8'd0, 8'd0, 8'd5, 8'd0}, 1, 8'd2};

        repeat (3) @(negedge clk);
        checkOutput("reset_gnt", o_gnt, 0);
        checkOutput("reset_rvalid", o_rvalid, 0);
        checkOutput("reset_busy", o_busy, 0);
        checkOutput("reset_mem", {o_mem_read, o_mem_enable, o_mem_addr}, 0);
        checkOutput("reset_rdata", {o_rdata, o_rid}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecs[v].req, vecs[v].addrs, vecs[v].expWin, vecs[v].expData);
        end

        // Reset while the access is in ISSUE: everything drops at once, pointer returns to 0.
        i_req      = 4'b1000;
        i_req_addr = {8'd60, 8'd0, 8'd0, 8'd0};
        got        = 1'b0;
        for (int w = 0; w < 12 && !got; w++) begin
            @(negedge clk);
            if (o_gnt != 4'b0) got = 1'b1;
        end
        checkOutput("rst_test_gnt", o_gnt, 4'b1000);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_mem", {o_mem_read, o_mem_enable, o_mem_addr}, 0);
        checkOutput("rst_async_gnt", o_gnt, 0);
        checkOutput("rst_async_busy", o_busy, 0);
        i_req = 4'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rvalidCount = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_rvalid) rvalidCount++;
        end
        checkOutput("rst_no_rvalid", rvalidCount, 0);
        refPtr = 0;
        applyStimulus(4'b1010, {8'd90, 8'd0, 8'd44, 8'd0}, 1, 8'd22);

        // A one-cycle req[1] pulse while busy must never be served.
        i_req      = 4'b0001;
        i_req_addr = {8'd0, 8'd0, 8'd0, 8'd20};
        got        = 1'b0;
        for (int w = 0; w < 12 && !got; w++) begin
            @(negedge clk);
            if (o_gnt != 4'b0) got = 1'b1;
        end
        checkOutput("pulse_test_gnt", o_gnt, 4'b0001);
        i_req       = 4'b0010;
        gnt1Count   = 0;
        rid1Count   = 0;
        rvalidCount = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (o_gnt[1]) gnt1Count++;
            if (o_rvalid) rvalidCount++;
            if (o_rvalid && o_rid == 2'd1) rid1Count++;
            if (c == 0) i_req = 4'b0;
        end
        checkOutput("pulse_gnt1", gnt1Count, 0);
        checkOutput("pulse_rid1", rid1Count, 0);
        checkOutput("pulse_rvalid_count", rvalidCount, 1);
        refPtr = 1;

        for (int r = 0; r < 40; r++) begin
            mask = 4'($urandom_range(1, 15));
            addrs = $urandom;
            expWin = modelWinner(mask, refPtr);
            applyStimulus(mask, addrs, expWin, addrs[expWin*8 +: 8] >> 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFail);
        $finish;
    end

endmodule
